// File: rtl/cci_mpf_shim_vtp_svc_req_rob.sv
// In-order VTP translation front end: tags requests, reorders OOO service responses, zero-latency issue.
// Responses visible 1 cycle after arrival; req_rdy drops when all tags are in use or the service stalls.
module cci_mpf_shim_vtp_svc_req_rob #(
  parameter int N_TAGS      = 8,
  parameter int VA_IDX_BITS = 36,
  parameter int PA_IDX_BITS = 26,
  parameter int META_BITS   = 8,
  localparam int TAG_BITS   = $clog2(N_TAGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_en,
  input  logic [VA_IDX_BITS-1:0] req_va,
  input  logic [META_BITS-1:0]   req_meta,
  output logic                   req_rdy,
  output logic                   svc_lookupEn,
  output logic [VA_IDX_BITS-1:0] svc_lookupPageVA,
  output logic [TAG_BITS-1:0]    svc_lookupTag,
  input  logic                   svc_lookupRdy,
  input  logic                   svc_rspValid,
  input  logic [PA_IDX_BITS-1:0] svc_rspPagePA,
  input  logic [TAG_BITS-1:0]    svc_rspTag,
  input  logic                   svc_rspIsBigPage,
  output logic                   rsp_valid,
  output logic [PA_IDX_BITS-1:0] rsp_pagePA,
  output logic                   rsp_isBigPage,
  output logic [META_BITS-1:0]   rsp_meta,
  input  logic                   rsp_deq,
  output logic [TAG_BITS:0]      n_outstanding,
  output logic                   err_bad_tag
);

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_PENDING,
    SLOT_DONE
  } slot_state_t;

  localparam logic [TAG_BITS:0] FULL_COUNT = (TAG_BITS+1)'(N_TAGS);

  slot_state_t            slotState [N_TAGS];
  logic [PA_IDX_BITS-1:0] slotPA    [N_TAGS];
  logic                   slotBig   [N_TAGS];
  logic [META_BITS-1:0]   slotMeta  [N_TAGS];

  logic [TAG_BITS-1:0] allocPtr;
  logic [TAG_BITS-1:0] retirePtr;
  logic [TAG_BITS:0]   count;

  logic accept;
  logic deq;
  logic rspHit;

  assign req_rdy          = reset_n && (count < FULL_COUNT) && svc_lookupRdy;
  assign accept           = req_en && req_rdy;
  assign svc_lookupEn     = accept;
  assign svc_lookupPageVA = req_va;
  assign svc_lookupTag    = allocPtr;

  // Head outputs come only from registered slot state, never from this cycle's inputs.
  assign rsp_valid     = (slotState[retirePtr] == SLOT_DONE);
  assign rsp_pagePA    = slotPA[retirePtr];
  assign rsp_isBigPage = slotBig[retirePtr];
  assign rsp_meta      = slotMeta[retirePtr];
  assign deq           = rsp_deq && rsp_valid;

  assign rspHit        = svc_rspValid && (slotState[svc_rspTag] == SLOT_PENDING);
  assign n_outstanding = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_TAGS; i++) begin
        slotState[i] <= SLOT_FREE;
        slotPA[i]    <= '0;
        slotBig[i]   <= 1'b0;
        slotMeta[i]  <= '0;
      end
      allocPtr    <= '0;
      retirePtr   <= '0;
      count       <= '0;
      err_bad_tag <= 1'b0;
    end else begin
      // Alloc targets a FREE slot, response a PENDING one, deq a DONE one: never the same slot.
      for (int i = 0; i < N_TAGS; i++) begin
        if (accept && (allocPtr == TAG_BITS'(i))) begin
          slotState[i] <= SLOT_PENDING;
          slotMeta[i]  <= req_meta;
        end
        if (rspHit && (svc_rspTag == TAG_BITS'(i))) begin
          slotState[i] <= SLOT_DONE;
          slotPA[i]    <= svc_rspPagePA;
          slotBig[i]   <= svc_rspIsBigPage;
        end
        if (deq && (retirePtr == TAG_BITS'(i))) begin
          slotState[i] <= SLOT_FREE;
        end
      end

      if (accept) allocPtr  <= allocPtr + TAG_BITS'(1);
      if (deq)    retirePtr <= retirePtr + TAG_BITS'(1);

      case ({accept, deq})
        2'b10:   count <= count + (TAG_BITS+1)'(1);
        2'b01:   count <= count - (TAG_BITS+1)'(1);
        default: count <= count;
      endcase

      if (svc_rspValid && !rspHit) err_bad_tag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cci_mpf_shim_vtp_svc_req_rob.sv
// Directed bench for the VTP service request reorder buffer.
module tb_cci_mpf_shim_vtp_svc_req_rob;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_en;
  logic [35:0] req_va;
  logic [7:0]  req_meta;
  logic        req_rdy;
  logic        svc_lookupEn;
  logic [35:0] svc_lookupPageVA;
  logic [2:0]  svc_lookupTag;
  logic        svc_lookupRdy;
  logic        svc_rspValid;
  logic [25:0] svc_rspPagePA;
  logic [2:0]  svc_rspTag;
  logic        svc_rspIsBigPage;
  logic        rsp_valid;
  logic [25:0] rsp_pagePA;
  logic        rsp_isBigPage;
  logic [7:0]  rsp_meta;
  logic        rsp_deq;
  logic [3:0]  n_outstanding;
  logic        err_bad_tag;

  int nErr = 0;
  int nChecks = 0;

  cci_mpf_shim_vtp_svc_req_rob dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_en           (req_en),
    .req_va           (req_va),
    .req_meta         (req_meta),
    .req_rdy          (req_rdy),
    .svc_lookupEn     (svc_lookupEn),
    .svc_lookupPageVA (svc_lookupPageVA),
    .svc_lookupTag    (svc_lookupTag),
    .svc_lookupRdy    (svc_lookupRdy),
    .svc_rspValid     (svc_rspValid),
    .svc_rspPagePA    (svc_rspPagePA),
    .svc_rspTag       (svc_rspTag),
    .svc_rspIsBigPage (svc_rspIsBigPage),
    .rsp_valid        (rsp_valid),
    .rsp_pagePA       (rsp_pagePA),
    .rsp_isBigPage    (rsp_isBigPage),
    .rsp_meta         (rsp_meta),
    .rsp_deq          (rsp_deq),
    .n_outstanding    (n_outstanding),
    .err_bad_tag      (err_bad_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen in the same window.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    req_en = 1'b0; req_va = '0; req_meta = '0;
    svc_lookupRdy = 1'b1;
    svc_rspValid = 1'b0; svc_rspPagePA = '0; svc_rspTag = '0; svc_rspIsBigPage = 1'b0;
    rsp_deq = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic issue(input logic [35:0] va, input logic [7:0] meta, input logic [2:0] expTag);
    req_en = 1'b1; req_va = va; req_meta = meta;
    #1;
    chk("issue_en", svc_lookupEn, 1'b1);
    chk("issue_tag", svc_lookupTag, expTag);
    chk("issue_va", svc_lookupPageVA, va);
    step();
    req_en = 1'b0;
  endtask

  task automatic respond(input logic [2:0] tag, input logic [25:0] pa, input logic big);
    svc_rspValid = 1'b1; svc_rspTag = tag; svc_rspPagePA = pa; svc_rspIsBigPage = big;
  endtask

  initial begin
    clearInputs();
    reset_n = 1'b0;
    req_en = 1'b1;
    step();
    chk("rst_req_rdy", req_rdy, 1'b0);
    chk("rst_lookupEn", svc_lookupEn, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_n_out", n_outstanding, 4'd0);
    chk("rst_err", err_bad_tag, 1'b0);
    req_en = 1'b0;
    reset_n = 1'b1;
    step();

    // Single request round trip
    chk("single_rdy", req_rdy, 1'b1);
    issue(36'h000000123, 8'h5A, 3'd0);
    chk("single_n_out1", n_outstanding, 4'd1);
    for (int i = 0; i < 4; i++) step();
    respond(3'd0, 26'h0ABCDEF, 1'b0);
    #1;
    chk("single_no_comb_path", rsp_valid, 1'b0);
    step();
    svc_rspValid = 1'b0;
    chk("single_rsp_valid", rsp_valid, 1'b1);
    chk("single_pa", rsp_pagePA, 26'h0ABCDEF);
    chk("single_meta", rsp_meta, 8'h5A);
    chk("single_big", rsp_isBigPage, 1'b0);
    rsp_deq = 1'b1;
    step();
    rsp_deq = 1'b0;
    chk("single_after_deq_valid", rsp_valid, 1'b0);
    chk("single_after_deq_n_out", n_outstanding, 4'd0);

    // Reorder: responses 2,0,1 delivered in request order
    doReset();
    issue(36'h10, 8'h01, 3'd0);
    issue(36'h20, 8'h02, 3'd1);
    issue(36'h30, 8'h03, 3'd2);
    rsp_deq = 1'b1;
    respond(3'd2, 26'h300, 1'b1);
    step();
    chk("reord_wait_head", rsp_valid, 1'b0);
    respond(3'd0, 26'h100, 1'b0);
    step();
    chk("reord_out0_valid", rsp_valid, 1'b1);
    chk("reord_out0_pa", rsp_pagePA, 26'h100);
    chk("reord_out0_meta", rsp_meta, 8'h01);
    respond(3'd1, 26'h200, 1'b0);
    step();
    svc_rspValid = 1'b0;
    chk("reord_out1_valid", rsp_valid, 1'b1);
    chk("reord_out1_pa", rsp_pagePA, 26'h200);
    chk("reord_out1_big", rsp_isBigPage, 1'b0);
    step();
    chk("reord_out2_valid", rsp_valid, 1'b1);
    chk("reord_out2_pa", rsp_pagePA, 26'h300);
    chk("reord_out2_big", rsp_isBigPage, 1'b1);
    chk("reord_out2_meta", rsp_meta, 8'h03);
    step();
    rsp_deq = 1'b0;
    chk("reord_drained_valid", rsp_valid, 1'b0);
    chk("reord_drained_n_out", n_outstanding, 4'd0);
    chk("reord_no_err", err_bad_tag, 1'b0);

    // Full and wrap
    doReset();
    for (int i = 0; i < 8; i++) issue(36'h1000 + 36'(i), 8'(i), 3'(i));
    req_en = 1'b1; req_va = 36'hBAD;
    #1;
    chk("full_req_rdy", req_rdy, 1'b0);
    chk("full_lookupEn", svc_lookupEn, 1'b0);
    chk("full_n_out", n_outstanding, 4'd8);
    step();
    req_en = 1'b0;
    chk("full_n_out_hold", n_outstanding, 4'd8);
    respond(3'd0, 26'h777, 1'b0);
    step();
    svc_rspValid = 1'b0;
    chk("full_head_valid", rsp_valid, 1'b1);
    chk("full_still_blocked", req_rdy, 1'b0);
    rsp_deq = 1'b1;
    step();
    rsp_deq = 1'b0;
    chk("wrap_req_rdy", req_rdy, 1'b1);
    chk("wrap_n_out", n_outstanding, 4'd7);
    issue(36'h999, 8'hEE, 3'd0);
    chk("wrap_n_out_refill", n_outstanding, 4'd8);

    // Service back-pressure
    doReset();
    issue(36'h40, 8'h40, 3'd0);
    issue(36'h41, 8'h41, 3'd1);
    svc_lookupRdy = 1'b0;
    req_en = 1'b1; req_va = 36'h42; req_meta = 8'h42;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_req_rdy", req_rdy, 1'b0);
      chk("bp_lookupEn", svc_lookupEn, 1'b0);
      step();
    end
    chk("bp_n_out", n_outstanding, 4'd2);
    svc_lookupRdy = 1'b1;
    issue(36'h42, 8'h42, 3'd2);
    chk("bp_n_out_after", n_outstanding, 4'd3);

    // Simultaneous accept and deq at count 4
    issue(36'h43, 8'h43, 3'd3);
    respond(3'd0, 26'h400, 1'b0);
    step();
    svc_rspValid = 1'b0;
    chk("sim_head_valid", rsp_valid, 1'b1);
    chk("sim_head_meta", rsp_meta, 8'h40);
    chk("sim_n_out_before", n_outstanding, 4'd4);
    rsp_deq = 1'b1;
    issue(36'h44, 8'h44, 3'd4);
    rsp_deq = 1'b0;
    chk("sim_n_out_after", n_outstanding, 4'd4);
    chk("sim_alloc_adv", svc_lookupTag, 3'd5);
    chk("sim_head_pending", rsp_valid, 1'b0);
    respond(3'd1, 26'h401, 1'b1);
    step();
    svc_rspValid = 1'b0;
    chk("sim_head_adv_valid", rsp_valid, 1'b1);
    chk("sim_head_adv_meta", rsp_meta, 8'h41);
    chk("sim_head_adv_pa", rsp_pagePA, 26'h401);

    // Bad tag and mid-stream reset
    doReset();
    respond(3'd5, 26'h555, 1'b0);
    step();
    svc_rspValid = 1'b0;
    chk("err_set", err_bad_tag, 1'b1);
    chk("err_no_valid", rsp_valid, 1'b0);
    chk("err_n_out", n_outstanding, 4'd0);
    step();
    chk("err_sticky", err_bad_tag, 1'b1);
    issue(36'h50, 8'h50, 3'd0);
    issue(36'h51, 8'h51, 3'd1);
    issue(36'h52, 8'h52, 3'd2);
    respond(3'd0, 26'h3FFFFFF, 1'b1);
    step();
    svc_rspValid = 1'b0;
    chk("rst2_head_valid_pre", rsp_valid, 1'b1);
    req_en = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("rst2_req_rdy", req_rdy, 1'b0);
    chk("rst2_lookupEn", svc_lookupEn, 1'b0);
    chk("rst2_rsp_valid", rsp_valid, 1'b0);
    chk("rst2_rsp_pa", rsp_pagePA, 26'h0);
    chk("rst2_rsp_big", rsp_isBigPage, 1'b0);
    chk("rst2_n_out", n_outstanding, 4'd0);
    chk("rst2_err", err_bad_tag, 1'b0);
    req_en = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("rst2_rel_n_out", n_outstanding, 4'd0);
    chk("rst2_rel_err", err_bad_tag, 1'b0);
    chk("rst2_rel_rdy", req_rdy, 1'b1);
    chk("rst2_rel_tag", svc_lookupTag, 3'd0);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule

// File: doc/cci_mpf_shim_vtp_svc_req_rob.md
Name: cci_mpf_shim_vtp_svc_req_rob

Overview:
- Client-side front end between a VTP pipeline shim and the shared VTP translation service.
- Accepts in-order 4KB-page translation requests and allocates a service tag to each.
- Issues requests on the service lookup port and collects the service's out-of-order responses by tag.
- Returns translations to the pipeline in original request order, with per-request client metadata carried through.

Parameters:
N_TAGS, 8, outstanding requests and reorder slots; must equal CCI_MPF_SHIM_VTP_MAX_SVC_REQS and be a power of 2.
VA_IDX_BITS, 36, 4KB VA page index width (42-6).
PA_IDX_BITS, 26, 4KB PA page index width (32-6).
META_BITS, 8, opaque client metadata width stored per request.

Ports:
clk  in  1  clock.
reset_n  in  1  async active-low reset.
req_en  in  1  pipeline request valid.
req_va  in  VA_IDX_BITS  virtual page to translate.
req_meta  in  META_BITS  client metadata returned with the response.
req_rdy  out  1  request accepted this cycle if req_en.
svc_lookupEn  out  1  service request enable.
svc_lookupPageVA  out  VA_IDX_BITS  service request VA.
svc_lookupTag  out  log2(N_TAGS)  service request tag.
svc_lookupRdy  in  1  service can accept a request.
svc_rspValid  in  1  service response valid.
svc_rspPagePA  in  PA_IDX_BITS  translated page.
svc_rspTag  in  log2(N_TAGS)  response tag.
svc_rspIsBigPage  in  1  2MB page flag.
rsp_valid  out  1  head translation available.
rsp_pagePA  out  PA_IDX_BITS  head PA.
rsp_isBigPage  out  1  head 2MB flag.
rsp_meta  out  META_BITS  head metadata.
rsp_deq  in  1  consume head; ignored when rsp_valid=0.
n_outstanding  out  log2(N_TAGS)+1  allocated slots.
err_bad_tag  out  1  sticky protocol error.

Behaviour:
- Reset (async assert, sync release): all slots FREE; alloc_ptr=0, retire_ptr=0, count=0; err_bad_tag=0. rsp_valid=0, req_rdy=0, svc_lookupEn=0 while reset_n low.
- Per-slot state machine:
  - FREE→PENDING on alloc.
  - PENDING→DONE on a matching svc response.
  - DONE→FREE on deq.
- Tag equals slot index, allocated circularly: tag = alloc_ptr.
- req_rdy = (count < N_TAGS) && svc_lookupRdy; combinational.
- svc_lookupEn = req_en && req_rdy, with svc_lookupPageVA = req_va and svc_lookupTag = alloc_ptr, in the same cycle (zero latency).
- On accept: store req_meta in slot[alloc_ptr], slot→PENDING, alloc_ptr++ (wraps mod N_TAGS), count++.
- On svc_rspValid with slot[tag] PENDING: write PA and big flag, slot→DONE at the next edge.
- rsp_valid = slot[retire_ptr]==DONE, driven from registered state; minimum response-to-rsp_valid latency is 1 cycle.
- rsp_pagePA, rsp_isBigPage and rsp_meta come from slot[retire_ptr] and are stable while rsp_valid && !rsp_deq.
- On rsp_deq && rsp_valid: slot→FREE, retire_ptr++ (wraps), count--.
- Accept and deq in the same cycle: count unchanged. At count=N_TAGS, a deq frees a slot and req_rdy may rise the next cycle.
- Service response and deq in the same cycle always target different slots, so both take effect.
- svc_rspValid for a slot in FREE or DONE: response dropped, no state change, err_bad_tag←1 (sticky until reset).
- Reset mid-operation discards all slots. The service must be reset concurrently; late responses after reset are flagged by err_bad_tag.
- No combinational path from svc_rsp* or rsp_deq to rsp_* outputs.

Test Plan:
- Single request: req VA 0x000000123 with meta 0x5A is accepted with tag 0. Five cycles later svc response tag 0, PA 0x0ABCDEF, big=0 → rsp_valid=1 the next cycle with PA 0x0ABCDEF, meta 0x5A. Deq → rsp_valid=0, n_outstanding=0.
- Reorder: three requests with VAs 0x10, 0x20, 0x30 get tags 0, 1, 2; responses arrive for tags 2, 0, 1 with PAs 0x300, 0x100, 0x200 and rsp_deq held at 1.
  - rsp_valid stays 0 until tag 0 arrives.
  - Outputs then appear in order 0x100, 0x200, 0x300.
  - The tag 2 response carries big=1, and it appears on the third output.
- Full and wrap: 8 requests with no responses → req_rdy=0 on the 9th and n_outstanding=8. Respond to tag 0 and deq → req_rdy=1 the next cycle, and the new request issues with tag 0.
- Back-pressure: svc_lookupRdy=0 with req_en=1 for 4 cycles → req_rdy=0, svc_lookupEn=0, count unchanged. Releasing svc_lookupRdy → accept with the expected tag.
- Simultaneous accept and deq at count=4 → count stays 4, head advances, alloc_ptr advances.
- Errors: response with tag 5 while slot 5 is FREE → err_bad_tag=1, no rsp_valid, stays 1 afterwards. Asserting reset_n=0 mid-stream with 3 pending → all outputs 0 immediately; after release, count=0 and err_bad_tag=0.
